// File: rtl/elevator_controller.sv
// ---------------------------------------------------------------------------
// elevator_controller
//   Car controller for the 4-floor Spartan Elevator. Latches floor-call
//   buttons, moves the car one floor at a time using a SCAN (keep-direction)
//   policy, times floor-to-floor travel and door dwell, and drives a one-hot
//   current-floor code for the seven-segment display stage.
//
// Parameters
//   TRAVEL_CYCLES : clk cycles to travel one floor (>= 2)
//   DOOR_CYCLES   : clk cycles the door stays open (>= 2)
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous, active-high reset
//   req[3:0]     in   floor-call buttons, bit i = floor i+1 (debounced, sync)
//   floor[3:0]   out  one-hot current floor (0001=F1 .. 1000=F4)
//   pending[3:0] out  latched, not-yet-served calls
//   door_open    out  high while in DOOR state
//   moving_up    out  high while in UP state
//   moving_down  out  high while in DOWN state
// ---------------------------------------------------------------------------
module elevator_controller #(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] floor,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       moving_up,
  output logic       moving_down
);

  localparam int unsigned TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DOOR
  } state_e;

  state_e        state_q, state_d;
  logic          dir_up_q, dir_up_d;
  logic [3:0]    floor_q, floor_d;
  logic [3:0]    pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          door_open_q, door_open_d;
  logic          moving_up_q, moving_up_d;
  logic          moving_down_q, moving_down_d;

  // Live call set: latched calls plus buttons pressed this cycle, so a call
  // arriving on the same edge as a state change is always considered.
  logic [3:0] act;
  logic [3:0] below_mask;
  logic [3:0] above_mask;
  logic       hit;
  logic       above;
  logic       below;

  // Candidate floors after one shift, saturated at the shaft ends so the
  // floor code can never lose its single set bit.
  logic [3:0] floor_up;
  logic [3:0] floor_dn;
  logic       hit_up_new;
  logic       above_up_new;
  logic       hit_dn_new;
  logic       below_dn_new;

  logic [3:0] clr;

  always_comb begin
    act        = pending_q | req;
    below_mask = floor_q - 4'd1;
    above_mask = ~(floor_q | below_mask);
    hit        = |(act & floor_q);
    above      = |(act & above_mask);
    below      = |(act & below_mask);

    floor_up     = floor_q[3] ? floor_q : {floor_q[2:0], 1'b0};
    floor_dn     = floor_q[0] ? floor_q : {1'b0, floor_q[3:1]};
    hit_up_new   = |(act & floor_up);
    above_up_new = |(act & ~(floor_up | (floor_up - 4'd1)));
    hit_dn_new   = |(act & floor_dn);
    below_dn_new = |(act & (floor_dn - 4'd1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dir_up_q      <= 1'b1;
      floor_q       <= 4'b0001;
      pending_q     <= '0;
      timer_q       <= '0;
      door_open_q   <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_up_q      <= dir_up_d;
      floor_q       <= floor_d;
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      door_open_q   <= door_open_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    floor_d  = floor_q;
    timer_d  = timer_q;
    clr      = '0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (hit) begin
          state_d = S_DOOR;
          clr     = floor_q;
        end else if (dir_up_q && above) begin
          state_d = S_UP;
        end else if (!dir_up_q && below) begin
          state_d = S_DOWN;
        end else if (above) begin
          dir_up_d = 1'b1;
          state_d  = S_UP;
        end else if (below) begin
          dir_up_d = 1'b0;
          state_d  = S_DOWN;
        end
      end

      // On arrival the stop/continue decision uses the floor being entered,
      // not the one being left; calls for the floor just left stay latched.
      S_UP: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          floor_d = floor_up;
          if (hit_up_new) begin
            state_d = S_DOOR;
            clr     = floor_up;
          end else if (!above_up_new) begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DOWN: begin
        if (timer_q == TRAVEL_LAST) begin
          timer_d = '0;
          floor_d = floor_dn;
          if (hit_dn_new) begin
            state_d = S_DOOR;
            clr     = floor_dn;
          end else if (!below_dn_new) begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // A press for the current floor restarts the dwell and is swallowed
      // by clr, so it never shows up as pending.
      S_DOOR: begin
        if (|(req & floor_q)) begin
          timer_d = '0;
          clr     = floor_q;
        end else if (timer_q == DOOR_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    pending_d = act & ~clr;
  end

  // Output logic, decoded from the next state so the status flops line up
  // with the state register.
  always_comb begin
    door_open_d   = (state_d == S_DOOR);
    moving_up_d   = (state_d == S_UP);
    moving_down_d = (state_d == S_DOWN);
  end

  assign floor       = floor_q;
  assign pending     = pending_q;
  assign door_open   = door_open_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;

endmodule

// File: tb/tb_elevator_controller.sv
// ---------------------------------------------------------------------------
// tb_elevator_controller
//   Directed bench for elevator_controller with TRAVEL_CYCLES=4,
//   DOOR_CYCLES=3. A table of per-cycle vectors covers a single call from F1;
//   hand-written sequences cover reset, door re-arm, all-floor calls, SCAN
//   ordering and reset during motion/dwell.
// ---------------------------------------------------------------------------
module tb_elevator_controller;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] floor;
  logic [3:0] pending;
  logic       door_open;
  logic       moving_up;
  logic       moving_down;

  int checks;
  int errors;

  elevator_controller #(
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .floor      (floor),
    .pending    (pending),
    .door_open  (door_open),
    .moving_up  (moving_up),
    .moving_down(moving_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] floor;
    logic [3:0] pend;
    logic       door;
    logic       up;
    logic       down;
  } vec_t;

  vec_t tab [13];

  // One clock: drive req, take the edge, sample 1 time unit later and check
  // the always-true properties of the outputs.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
    checks++;
    if (!$onehot(floor) || !$onehot0({door_open, moving_up, moving_down})) begin
      errors++;
      $display("FAIL invariant: got floor=%b status(door,up,down)=%b%b%b, required one-hot floor and at most one status bit",
               floor, door_open, moving_up, moving_down);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(4'b0000);
  endtask

  task automatic expect_out(input string name, input logic [3:0] f, input logic [3:0] p,
                            input logic d, input logic u, input logic dn);
    checks++;
    if ({floor, pending, door_open, moving_up, moving_down} !== {f, p, d, u, dn}) begin
      errors++;
      $display("FAIL %s: got floor=%b pending=%b door=%b up=%b down=%b, required floor=%b pending=%b door=%b up=%b down=%b",
               name, floor, pending, door_open, moving_up, moving_down, f, p, d, u, dn);
    end
  endtask

  // Reset asserted mid-cycle; outputs must change before any clock edge.
  task automatic do_reset(input string name);
    req = 4'b0000;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_out(name, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] d_floor [4];
  logic [3:0] d_pend  [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = 4'b0000;

    // Single call for F3 from idle at F1.
    tab[0]  = '{4'b0100, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[1]  = '{4'b0000, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[2]  = '{4'b0000, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{4'b0000, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{4'b0000, 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[5]  = '{4'b0000, 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{4'b0000, 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[7]  = '{4'b0000, 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
    tab[9]  = '{4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
    tab[10] = '{4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
    tab[11] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0};
    tab[12] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0};

    d_floor[0] = 4'b0001; d_pend[0] = 4'b1110;
    d_floor[1] = 4'b0010; d_pend[1] = 4'b1100;
    d_floor[2] = 4'b0100; d_pend[2] = 4'b1000;
    d_floor[3] = 4'b1000; d_pend[3] = 4'b0000;

    do_reset("reset_initial");

    for (int i = 0; i < 13; i++) begin
      step(tab[i].req);
      expect_out($sformatf("vecA[%0d]", i), tab[i].floor, tab[i].pend,
                 tab[i].door, tab[i].up, tab[i].down);
    end

    do_reset("reset_from_f3");

    // Call for the current floor, then a re-press on the last dwell cycle.
    step(4'b0001);
    expect_out("c_door_enter", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    run(2);
    expect_out("c_door_last", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0001);
    expect_out("c_rearm", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    run(2);
    expect_out("c_rearm_hold", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0000);
    expect_out("c_door_close", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);

    // All four floors called at once from F1.
    step(4'b1111);
    expect_out("d_f1_door", 4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      run(3);
      expect_out($sformatf("d_idle[%0d]", k), d_floor[k-1], d_pend[k-1], 1'b0, 1'b0, 1'b0);
      step(4'b0000);
      expect_out($sformatf("d_up[%0d]", k), d_floor[k-1], d_pend[k-1], 1'b0, 1'b1, 1'b0);
      run(4);
      expect_out($sformatf("d_stop[%0d]", k), d_floor[k], d_pend[k], 1'b1, 1'b0, 1'b0);
    end
    run(3);
    expect_out("d_f4_idle", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000);
    expect_out("d_f4_stay", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);

    do_reset("reset_from_f4");

    // SCAN: going up to F4, a call for F1 must wait until F4 is served; a
    // call for F2 on the edge that leaves F2 must be kept.
    step(4'b1000);
    expect_out("s_start", 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
    run(3);
    step(4'b0000);
    expect_out("s_at_f2", 4'b0010, 4'b1000, 1'b0, 1'b1, 1'b0);
    step(4'b0001);
    expect_out("s_req_f1", 4'b0010, 4'b1001, 1'b0, 1'b1, 1'b0);
    run(2);
    step(4'b0010);
    expect_out("s_f3_same_edge", 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0);
    run(4);
    expect_out("s_f4_door", 4'b1000, 4'b0011, 1'b1, 1'b0, 1'b0);
    run(3);
    expect_out("s_f4_idle", 4'b1000, 4'b0011, 1'b0, 1'b0, 1'b0);
    step(4'b0000);
    expect_out("s_down", 4'b1000, 4'b0011, 1'b0, 1'b0, 1'b1);
    run(4);
    expect_out("s_f3_pass", 4'b0100, 4'b0011, 1'b0, 1'b0, 1'b1);
    run(4);
    expect_out("s_f2_door", 4'b0010, 4'b0001, 1'b1, 1'b0, 1'b0);
    run(3);
    expect_out("s_f2_idle", 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0000);
    expect_out("s_down_again", 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b1);
    run(4);
    expect_out("s_f1_door", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    run(3);
    expect_out("s_f1_idle", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset while travelling and while the door is open.
    step(4'b0100);
    run(5);
    expect_out("m_moving", 4'b0010, 4'b0100, 1'b0, 1'b1, 1'b0);
    do_reset("reset_mid_move");
    step(4'b0000);
    expect_out("m_after_reset", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b1000);
    run(4);
    expect_out("m_at_f2", 4'b0010, 4'b1000, 1'b0, 1'b1, 1'b0);
    step(4'b0010);
    expect_out("m_no_reverse", 4'b0010, 4'b1010, 1'b0, 1'b1, 1'b0);
    do_reset("reset_mid_move2");
    step(4'b0001);
    expect_out("m_door", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    do_reset("reset_mid_door");
    step(4'b0000);
    expect_out("m_after_door_reset", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
